// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline main control: opcodes, ALUOp codes, stage control bundles.
// Latency: none, declarations only.
// Backpressure: not applicable.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALUOP_ADD  = 3'b000;
    localparam logic [2:0] ALUOP_BR   = 3'b001;
    localparam logic [2:0] ALUOP_R    = 3'b010;
    localparam logic [2:0] ALUOP_I    = 3'b011;
    localparam logic [2:0] ALUOP_LUI  = 3'b100;
    localparam logic [2:0] ALUOP_LINK = 3'b101;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       jump;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder for the instruction in ID: EX/MEM/WB control bundles, illegal flag, rs-use flags.
// Latency: purely combinational.
// Backpressure: none; ports: op in, ex/mem/wb bundles, illegal, uses_rs1, uses_rs2 out.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] op,
    output ex_ctrl_t   ex,
    output mem_ctrl_t  mem,
    output wb_ctrl_t   wb,
    output logic       illegal,
    output logic       uses_rs1,
    output logic       uses_rs2
);

    always_comb begin
        ex       = '0;
        mem      = '0;
        wb       = '0;
        illegal  = 1'b0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (op)
            OP_R: begin
                wb.reg_write = 1'b1;
                ex.alu_op    = ALUOP_R;
                uses_rs2     = 1'b1;
            end
            OP_IMM: begin
                wb.reg_write = 1'b1;
                ex.alu_op    = ALUOP_I;
                ex.alu_src   = 1'b1;
            end
            OP_LOAD: begin
                wb.reg_write  = 1'b1;
                wb.mem_to_reg = 1'b1;
                mem.mem_read  = 1'b1;
                ex.alu_op     = ALUOP_ADD;
                ex.alu_src    = 1'b1;
            end
            OP_STORE: begin
                mem.mem_write = 1'b1;
                ex.alu_op     = ALUOP_ADD;
                ex.alu_src    = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                ex.alu_op = ALUOP_BR;
                ex.branch = 1'b1;
                uses_rs2  = 1'b1;
            end
            OP_JAL: begin
                wb.reg_write = 1'b1;
                ex.alu_op    = ALUOP_LINK;
                ex.jump      = 1'b1;
                uses_rs1     = 1'b0;
            end
            OP_JALR: begin
                wb.reg_write = 1'b1;
                ex.alu_op    = ALUOP_LINK;
                ex.alu_src   = 1'b1;
                ex.jump      = 1'b1;
            end
            OP_LUI: begin
                wb.reg_write = 1'b1;
                ex.alu_op    = ALUOP_LUI;
                ex.alu_src   = 1'b1;
                uses_rs1     = 1'b0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Main control for a 5-stage RV32I pipe: decode in ID, ID/EX, EX/MEM, MEM/WB control registers,
// load-use bubbles, redirect flush, memory freeze, saturating stall/flush counters.
// Latency: ex_* 1 cycle after ID, mem_* 2, wb_* 3; mem_stall_i freezes every stage register.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int ALUOP_W   = 3,
    parameter int CNT_W     = 16,
    parameter int HAZARD_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [6:0]        op_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              redirect_i,
    input  logic              mem_stall_i,
    output logic [ALUOP_W-1:0] ex_alu_op_o,
    output logic              ex_alu_src_o,
    output logic              ex_branch_o,
    output logic              ex_jump_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [REG_AW-1:0] mem_rd_o,
    output logic              wb_reg_write_o,
    output logic              wb_mem_to_reg_o,
    output logic [REG_AW-1:0] wb_rd_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              stall_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ex_ctrl_t          dec_ex;
    mem_ctrl_t         dec_mem;
    wb_ctrl_t          dec_wb;
    logic              dec_illegal;
    logic              uses_rs1;
    logic              uses_rs2;
    logic [REG_AW-1:0] dec_rd;

    ex_ctrl_t          idex_ex;
    mem_ctrl_t         idex_mem;
    wb_ctrl_t          idex_wb;
    logic [REG_AW-1:0] idex_rd;
    mem_ctrl_t         exmem_mem;
    wb_ctrl_t          exmem_wb;
    logic [REG_AW-1:0] exmem_rd;
    wb_ctrl_t          memwb_wb;
    logic [REG_AW-1:0] memwb_rd;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    logic load_use;
    logic bubble;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic stall;

    ctrl_decode u_decode (
        .op       (op_i),
        .ex       (dec_ex),
        .mem      (dec_mem),
        .wb       (dec_wb),
        .illegal  (dec_illegal),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    // Non-writing instructions carry rd=0 so downstream forwarding never matches them.
    assign dec_rd = dec_wb.reg_write ? rd_i : '0;

    always_comb begin
        load_use = 1'b0;
        if (HAZARD_EN != 0) begin
            load_use = idex_mem.mem_read && (idex_rd != '0) &&
                       ((uses_rs1 && (idex_rd == rs1_i)) ||
                        (uses_rs2 && (idex_rd == rs2_i)));
        end
    end

    // Reset beats freeze beats redirect beats load-use.
    always_comb begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        stall      = 1'b0;
        bubble     = 1'b0;
        if (!rst_i) begin
            bubble = 1'b1;
        end else if (mem_stall_i) begin
            bubble = 1'b0;
        end else if (redirect_i) begin
            bubble     = 1'b1;
            ifid_flush = 1'b1;
            pc_write   = 1'b1;
            ifid_write = 1'b1;
        end else if (load_use) begin
            bubble = 1'b1;
            stall  = 1'b1;
        end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            idex_ex   <= '0;
            idex_mem  <= '0;
            idex_wb   <= '0;
            idex_rd   <= '0;
            exmem_mem <= '0;
            exmem_wb  <= '0;
            exmem_rd  <= '0;
            memwb_wb  <= '0;
            memwb_rd  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!mem_stall_i) begin
            if (bubble) begin
                idex_ex  <= '0;
                idex_mem <= '0;
                idex_wb  <= '0;
                idex_rd  <= '0;
            end else begin
                idex_ex  <= dec_ex;
                idex_mem <= dec_mem;
                idex_wb  <= dec_wb;
                idex_rd  <= dec_rd;
            end
            exmem_mem <= idex_mem;
            exmem_wb  <= idex_wb;
            exmem_rd  <= idex_rd;
            memwb_wb  <= exmem_wb;
            memwb_rd  <= exmem_rd;
            if (ifid_flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign ex_alu_op_o     = ALUOP_W'(idex_ex.alu_op);
    assign ex_alu_src_o    = idex_ex.alu_src;
    assign ex_branch_o     = idex_ex.branch;
    assign ex_jump_o       = idex_ex.jump;
    assign ex_rd_o         = idex_rd;
    assign mem_read_o      = exmem_mem.mem_read;
    assign mem_write_o     = exmem_mem.mem_write;
    assign mem_rd_o        = exmem_rd;
    assign wb_reg_write_o  = memwb_wb.reg_write;
    assign wb_mem_to_reg_o = memwb_wb.mem_to_reg;
    assign wb_rd_o         = memwb_rd;
    assign pc_write_o      = pc_write;
    assign ifid_write_o    = ifid_write;
    assign ifid_flush_o    = ifid_flush;
    assign stall_o         = stall;
    assign illegal_o       = dec_illegal;
    assign stall_cnt_o     = stall_cnt;
    assign flush_cnt_o     = flush_cnt;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit (counters narrowed to 2 bits so saturation is reachable).
// Inputs change 1 time unit after a rising edge; outputs are sampled before the next edge.
// Summary line reports error and check counts.
module tb_ctrl_pipe_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] op = 7'b0110011;
    logic [4:0] rs1 = 5'd0;
    logic [4:0] rs2 = 5'd0;
    logic [4:0] rd = 5'd0;
    logic       redirect = 1'b0;
    logic       mem_stall = 1'b0;

    logic [2:0] ex_alu_op;
    logic       ex_alu_src, ex_branch, ex_jump;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
    logic       pc_write, ifid_write, ifid_flush, stall, illegal;
    logic [1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    // Bundle bits: [9]RegWrite [8]MemtoReg [7]MemRead [6]MemWrite [5:3]ALUOp [2]ALUSrc [1]Branch [0]Jump
    logic [6:0] ops [0:7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                              7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    logic [9:0] tbl [0:7] = '{10'b1000_010_000, 10'b1000_011_100, 10'b1110_000_100,
                              10'b0001_000_100, 10'b0000_001_010, 10'b1000_101_001,
                              10'b1000_101_101, 10'b1000_100_100};

    ctrl_pipe_unit #(.REG_AW(5), .ALUOP_W(3), .CNT_W(2), .HAZARD_EN(1)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .op_i            (op),
        .rs1_i           (rs1),
        .rs2_i           (rs2),
        .rd_i            (rd),
        .redirect_i      (redirect),
        .mem_stall_i     (mem_stall),
        .ex_alu_op_o     (ex_alu_op),
        .ex_alu_src_o    (ex_alu_src),
        .ex_branch_o     (ex_branch),
        .ex_jump_o       (ex_jump),
        .ex_rd_o         (ex_rd),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .mem_rd_o        (mem_rd),
        .wb_reg_write_o  (wb_reg_write),
        .wb_mem_to_reg_o (wb_mem_to_reg),
        .wb_rd_o         (wb_rd),
        .pc_write_o      (pc_write),
        .ifid_write_o    (ifid_write),
        .ifid_flush_o    (ifid_flush),
        .stall_o         (stall),
        .illegal_o       (illegal),
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [6:0] o, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d);
        op  = o;
        rs1 = a;
        rs2 = b;
        rd  = d;
    endtask

    task automatic chk_ex(input string tag, input logic [9:0] e, input logic [4:0] r);
        chk({tag, ".ex"}, {26'd0, ex_alu_op, ex_alu_src, ex_branch, ex_jump}, {26'd0, e[5:0]});
        chk({tag, ".ex_rd"}, {27'd0, ex_rd}, {27'd0, r});
    endtask

    task automatic chk_mem(input string tag, input logic [9:0] e, input logic [4:0] r);
        chk({tag, ".mem"}, {30'd0, mem_read, mem_write}, {30'd0, e[7:6]});
        chk({tag, ".mem_rd"}, {27'd0, mem_rd}, {27'd0, r});
    endtask

    task automatic chk_wb(input string tag, input logic [9:0] e, input logic [4:0] r);
        chk({tag, ".wb"}, {30'd0, wb_reg_write, wb_mem_to_reg}, {30'd0, e[9:8]});
        chk({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, r});
    endtask

    // Expected bundle/rd of the k-th sweep instruction; outside 0..7 the pipe holds NOPs.
    function automatic logic [9:0] ent(input int k);
        if (k < 0 || k > 7) return 10'd0;
        return tbl[k];
    endfunction

    function automatic logic [4:0] erd(input int k);
        logic [9:0] e;
        e = ent(k);
        return e[9] ? 5'(k + 1) : 5'd0;
    endfunction

    initial begin
        // Reset held 3 cycles with an R-type in ID.
        set_id(7'b0110011, 5'd1, 5'd2, 5'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ex("rst", 10'd0, 5'd0);
            chk_mem("rst", 10'd0, 5'd0);
            chk_wb("rst", 10'd0, 5'd0);
            chk("rst.pc_write", {31'd0, pc_write}, 32'd0);
            chk("rst.ifid_write", {31'd0, ifid_write}, 32'd0);
        end
        rst = 1'b1;
        #1;
        chk("rel.pc_write", {31'd0, pc_write}, 32'd1);
        chk("rel.stall_cnt", {30'd0, stall_cnt}, 32'd0);
        chk("rel.flush_cnt", {30'd0, flush_cnt}, 32'd0);

        // Decode sweep then three illegal opcodes draining the pipe.
        for (int k = 0; k < 11; k++) begin
            set_id((k < 8) ? ops[k] : 7'b1111111, 5'd0, 5'd0, 5'(k + 1));
            #1;
            chk($sformatf("sw%0d.illegal", k), {31'd0, illegal}, (k < 8) ? 32'd0 : 32'd1);
            tick();
            chk_ex($sformatf("sw%0d", k), ent(k), erd(k));
            chk_mem($sformatf("sw%0d", k), ent(k - 1), erd(k - 1));
            chk_wb($sformatf("sw%0d", k), ent(k - 2), erd(k - 2));
        end

        // Load-use: lw x5 then add using x5.
        set_id(7'b0000011, 5'd0, 5'd0, 5'd5);
        tick();
        set_id(7'b0110011, 5'd5, 5'd0, 5'd6);
        #1;
        chk("lu.stall", {31'd0, stall}, 32'd1);
        chk("lu.pc_write", {31'd0, pc_write}, 32'd0);
        chk("lu.ifid_write", {31'd0, ifid_write}, 32'd0);
        tick();
        chk_ex("lu.bubble", 10'd0, 5'd0);
        chk_mem("lu.lw", 10'b1110_000_100, 5'd5);
        chk("lu.stall_cnt", {30'd0, stall_cnt}, 32'd1);
        chk("lu.stall_after", {31'd0, stall}, 32'd0);
        tick();
        chk_ex("lu.add", 10'b1000_010_000, 5'd6);

        // Load to x0 never stalls.
        set_id(7'b0000011, 5'd0, 5'd0, 5'd0);
        tick();
        set_id(7'b0110011, 5'd0, 5'd0, 5'd6);
        #1;
        chk("lu0.stall", {31'd0, stall}, 32'd0);
        chk("lu0.pc_write", {31'd0, pc_write}, 32'd1);
        tick();
        chk("lu0.stall_cnt", {30'd0, stall_cnt}, 32'd1);

        // Redirect wins over a simultaneous load-use on rs2.
        set_id(7'b0000011, 5'd0, 5'd0, 5'd3);
        tick();
        set_id(7'b0110011, 5'd0, 5'd3, 5'd7);
        redirect = 1'b1;
        #1;
        chk("rd.flush", {31'd0, ifid_flush}, 32'd1);
        chk("rd.stall", {31'd0, stall}, 32'd0);
        chk("rd.pc_write", {31'd0, pc_write}, 32'd1);
        tick();
        redirect = 1'b0;
        chk_ex("rd.bubble", 10'd0, 5'd0);
        chk("rd.flush_cnt", {30'd0, flush_cnt}, 32'd1);
        chk("rd.stall_cnt", {30'd0, stall_cnt}, 32'd1);

        // Freeze with a load in MEM; a redirect during freeze is ignored.
        set_id(7'b0000011, 5'd0, 5'd0, 5'd9);
        tick();
        set_id(7'b1111111, 5'd0, 5'd0, 5'd0);
        tick();
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            redirect = (i == 1);
            #1;
            chk($sformatf("fz%0d.pc_write", i), {31'd0, pc_write}, 32'd0);
            chk($sformatf("fz%0d.ifid_write", i), {31'd0, ifid_write}, 32'd0);
            chk($sformatf("fz%0d.flush", i), {31'd0, ifid_flush}, 32'd0);
            tick();
            chk_mem($sformatf("fz%0d", i), 10'b1110_000_100, 5'd9);
            chk($sformatf("fz%0d.cnts", i), {28'd0, stall_cnt, flush_cnt}, 32'h5);
        end
        mem_stall = 1'b0;
        redirect = 1'b0;
        #1;
        chk("fz.resume_pc", {31'd0, pc_write}, 32'd1);
        tick();
        chk_wb("fz.resume", 10'b1100_000_000, 5'd9);
        chk("fz.mem_read", {31'd0, mem_read}, 32'd0);

        // Five more load-use stalls drive the 2-bit counter into saturation.
        for (int i = 0; i < 5; i++) begin
            set_id(7'b0000011, 5'd0, 5'd0, 5'd4);
            tick();
            set_id(7'b0110011, 5'd4, 5'd0, 5'd6);
            #1;
            chk($sformatf("sat%0d.stall", i), {31'd0, stall}, 32'd1);
            tick();
            chk($sformatf("sat%0d.cnt", i), {30'd0, stall_cnt}, (i == 0) ? 32'd2 : 32'd3);
        end

        // Reset mid-flight discards everything, even a pending load-use.
        set_id(7'b0000011, 5'd0, 5'd0, 5'd4);
        tick();
        set_id(7'b0110011, 5'd4, 5'd0, 5'd6);
        rst = 1'b0;
        #1;
        chk("mrst.stall", {31'd0, stall}, 32'd0);
        chk("mrst.pc_write", {31'd0, pc_write}, 32'd0);
        tick();
        chk_ex("mrst", 10'd0, 5'd0);
        chk_mem("mrst", 10'd0, 5'd0);
        chk_wb("mrst", 10'd0, 5'd0);
        chk("mrst.cnts", {28'd0, stall_cnt, flush_cnt}, 32'd0);
        rst = 1'b1;
        set_id(7'b1111111, 5'd0, 5'd0, 5'd0);
        #1;
        chk("mrst.rel_pc", {31'd0, pc_write}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Next-generation main control for the 5-stage RV32I pipeline.
- Decodes the opcode in ID and carries registered EX/MEM/WB control bundles through the ID/EX, EX/MEM and MEM/WB stage registers.
- Detects load-use hazards and inserts bubbles; applies branch/jump flush and whole-pipe memory freeze.
- Adds JAL/JALR/LUI decode, a 3-bit ALUOp, illegal-opcode flagging and saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register-index width.
- ALUOP_W, 3, ALUOp field width; must be ≥3.
- CNT_W, 16, width of each performance counter.
- HAZARD_EN, 1, 0 disables load-use detection (stall_o is held 0).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- op_i  in  7  opcode of the instruction in ID
- rs1_i  in  REG_AW  rs1 index in ID
- rs2_i  in  REG_AW  rs2 index in ID
- rd_i  in  REG_AW  rd index in ID
- redirect_i  in  1  taken branch/jump resolved in EX
- mem_stall_i  in  1  data memory busy; freeze pipe
- ex_alu_op_o  out  ALUOP_W  ALUOp in EX
- ex_alu_src_o  out  1  ALUSrc in EX
- ex_branch_o  out  1  Branch in EX
- ex_jump_o  out  1  JAL/JALR in EX
- ex_rd_o  out  REG_AW  rd in EX
- mem_read_o  out  1  MemRead in MEM
- mem_write_o  out  1  MemWrite in MEM
- mem_rd_o  out  REG_AW  rd in MEM
- wb_reg_write_o  out  1  RegWrite in WB
- wb_mem_to_reg_o  out  1  MemtoReg in WB
- wb_rd_o  out  REG_AW  rd in WB
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID register enable
- ifid_flush_o  out  1  zero IF/ID
- stall_o  out  1  load-use bubble inserted this cycle
- illegal_o  out  1  unknown opcode in ID (combinational)
- stall_cnt_o  out  CNT_W  saturating load-use stall count
- flush_cnt_o  out  CNT_W  saturating redirect count

Behaviour:
- Decode (combinational, ID). Fields: RegWrite, MemtoReg, MemRead, MemWrite, ALUOp, ALUSrc, Branch, Jump.
  - 0110011 R-type: 1,0,0,0,010,0,0,0
  - 0010011 I-arith: 1,0,0,0,011,1,0,0
  - 0000011 lw: 1,1,1,0,000,1,0,0
  - 0100011 sw: 0,0,0,1,000,1,0,0
  - 1100011 beq: 0,0,0,0,001,0,1,0
  - 1101111 jal: 1,0,0,0,101,0,0,1
  - 1100111 jalr: 1,0,0,0,101,1,0,1
  - 0110111 lui: 1,0,0,0,100,1,0,0
  - Any other opcode: all fields 0 (NOP), illegal_o=1.
- rd is zeroed for sw and beq, so the stage rd of a non-writing instruction is always 0.
- Hazard (HAZARD_EN=1):
  - load_use = ID/EX.MemRead & ex_rd≠0 & (ex_rd==rs1_i | (ex_rd==rs2_i & op uses rs2)).
  - Opcodes that use rs2: R-type, sw, beq.
  - Opcodes that use rs1: all except jal and lui. If the ID opcode does not use rs1, the rs1 compare is masked.
- Priority per cycle, highest first:
  1. !rst_i: all stage registers and counters clear to 0; pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, stall_o=0.
  2. mem_stall_i: all three stage registers hold; pc_write_o=0, ifid_write_o=0. stall_o and ifid_flush_o are 0. Counters hold. A redirect_i seen during freeze is not acted on; EX re-presents it once the freeze releases.
  3. redirect_i: ID/EX loads a bubble (all 0); ifid_flush_o=1; pc_write_o=1; ifid_write_o=1. load_use is ignored. flush_cnt increments.
  4. load_use: ID/EX loads a bubble; pc_write_o=0; ifid_write_o=0; stall_o=1. stall_cnt increments.
  5. Otherwise: ID/EX loads the decoded bundle; pc_write_o=1; ifid_write_o=1.
- EX/MEM and MEM/WB advance every non-frozen cycle; a bubble propagates as zeros.
- Latency: a decoded field appears on its ex_* output 1 cycle after ID, mem_* after 2 cycles, wb_* after 3 cycles.
- Counters saturate at 2^CNT_W−1; no wrap.
- Reset mid-operation discards all in-flight control. First post-reset cycle: all stage outputs 0, pc_write_o=1.

Decomposition:
- Shared package ctrl_pkg holds:
  - Opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI.
  - ALUOp constants ALUOP_ADD/BR/R/I/LUI/LINK.
  - Struct typedefs ex_ctrl_t, mem_ctrl_t, wb_ctrl_t.
- Sub-module ctrl_decode holds the purely combinational opcode table, with illegal output and rs-use flags.
- Hazard logic, stage registers and counters stay in the top.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles with op_i=0110011, then release → all stage outputs 0 during reset. Cycle after release: pc_write_o=1, counters 0.
- Decode sweep: issue each of the 8 opcodes back-to-back, no hazards → ex_* outputs match the table 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later. op_i=1111111 → illegal_o=1 and a NOP bundle.
- Load-use: lw rd=5, then add rs1=5 → one cycle with stall_o=1, pc_write_o=0, ifid_write_o=0, ex_* all 0 the next cycle, stall_cnt_o=1. Repeat with rd=0 → no stall.
- Redirect beats load-use: lw rd=3 in EX with redirect_i=1 while ID holds add rs2=3 → ifid_flush_o=1, stall_o=0, flush_cnt_o=1, ID/EX bubble.
- Freeze: mem_stall_i=1 for 4 cycles with a lw in MEM → mem_read_o=1 and mem_rd_o stable, pc_write_o=0 throughout, counters unchanged. Pipe resumes on release.
- Saturation: CNT_W=2, force 5 stalls → stall_cnt_o=3 and stays at 3.
